rs_syndrome_calc: RTL
=====================

RS_SYNDROME_CALC -- requirements
Module: rs_syndrome_calc

Interface
REQ-001 SHALL have parameter SYM_W, default 4, GF(2^4) symbol width; fixed and not overridden.
REQ-002 SHALL have parameter N_SYM, default 15, codeword length in symbols.
REQ-003 SHALL have parameter N_SYND, default 6, number of syndromes (N-K for RS(15,9)).
REQ-004 SHALL have port clk, input, 1, the single clock for all logic.
REQ-005 SHALL have port reset, input, 1, synchronous active-high reset sampled on rising clk.
REQ-006 SHALL have port codeWordVector, input, 60, received codeword; symbol i at bits [4i+3:4i], symbol 14 is the highest-degree coefficient.
REQ-007 SHALL have port startSyndrome, input, 1, single-cycle request to process codeWordVector.
REQ-008 SHALL have port syndromeBusy, output, 1, high while a codeword is being processed.
REQ-009 SHALL have port syndromeValid, output, 1, one-cycle pulse when results are ready.
REQ-010 SHALL have port syndromePacked, output, 24, S1 in [3:0] through S6 in [23:20].
REQ-011 SHALL have port errorDetected, output, 1, high when any syndrome is nonzero.

Function
REQ-012 SHALL use GF(16) with primitive polynomial x^4+x+1; alpha = 4'b0010.
REQ-013 SHALL compute S_j = r(alpha^j), j = 1..6, by Horner's rule.
REQ-014 SHALL implement states IDLE, ACCUM, DONE.
REQ-015 IDLE: startSyndrome high -> capture codeWordVector into a 60-bit register, clear all six accumulators, clear the symbol counter to 14, go to ACCUM.
REQ-016 ACCUM: each cycle SHALL update S_j <= (S_j * alpha^j) XOR r_cnt for every j in parallel, then decrement the counter.
REQ-017 ACCUM SHALL last exactly 15 cycles, processing symbol 14 down to symbol 0; after symbol 0 it SHALL go to DONE.
REQ-018 DONE SHALL assert syndromeValid for exactly one cycle, drive errorDetected, and return to IDLE.
REQ-019 Latency SHALL be 17 cycles: start sampled at edge 0, syndromeValid high after edge 16.
REQ-020 syndromeBusy SHALL be high in ACCUM and DONE and low in IDLE.
REQ-021 startSyndrome while syndromeBusy is high SHALL be ignored with no effect on the operation in progress.
REQ-022 Changes on codeWordVector after capture SHALL NOT affect results.
REQ-023 syndromePacked and errorDetected SHALL hold their last values until the next DONE.
REQ-024 Constant multiplication by alpha^j SHALL be pure XOR logic with 4-bit results and no carries.
REQ-025 startSyndrome in the same cycle that DONE returns to IDLE SHALL be accepted on the next IDLE cycle only.

Reset
REQ-026 On reset, state SHALL be IDLE; the counter, accumulators and capture register SHALL be 0.
REQ-027 On reset, syndromeBusy, syndromeValid, errorDetected and syndromePacked SHALL be 0.
REQ-028 Reset asserted mid-ACCUM SHALL abort the operation with no syndromeValid pulse, and reset SHALL override startSyndrome.

Structure
REQ-029 Package rs_pkg SHALL hold SYM_W, N_SYM, K_SYM=9, N_SYND, PRIM_POLY=4'b0011, the alpha^1..alpha^6 constant table, and the state enum type.
REQ-030 Sub-module gf16_mult_const SHALL compute (4-bit input times a constant power of alpha) and SHALL be instantiated six times.
REQ-031 The block SHALL sit downstream of the encoder and accept its 60-bit codeWordVector unchanged.

Verification
REQ-032 Codeword all zeros, start pulse -> syndromeValid at cycle 16, syndromePacked=24'h000000, errorDetected=0.
REQ-033 Valid encoder output for message 36'h0000000E7, fed directly from the encoder -> syndromePacked=0, errorDetected=0.
REQ-034 Codeword all zero except bits[3:0]=4'h1 -> every S_j=4'h1, syndromePacked=24'h111111, errorDetected=1.
REQ-035 Codeword all zero except bits[7:4]=4'h1 -> S1..S6 = 2,4,8,3,6,C, syndromePacked=24'hC63842.
REQ-036 Second start pulse at cycle 5 of an operation -> ignored, single syndromeValid at cycle 16 with the first codeword's result.
REQ-037 Reset at cycle 8 of an operation -> no syndromeValid; all outputs 0 the next cycle; a fresh start then completes normally.

Source files
------------

// File: rtl/rs_pkg.sv
// Shared constants, types and GF(16) helper for the RS(15,9) syndrome block.
// Field is GF(2^4) built on x^4+x+1; alpha = 4'b0010.
package rs_pkg;

    localparam int SYM_W  = 4;
    localparam int N_SYM  = 15;
    localparam int K_SYM  = 9;
    localparam int N_SYND = N_SYM - K_SYM;

    // Low bits of the primitive polynomial: x^4 folds back to x+1.
    localparam logic [3:0] PRIM_POLY = 4'b0011;

    // alpha^j for j = 1..6, indexed by j.
    localparam logic [6:1][3:0] ALPHA_POW = {
        4'hC, 4'h6, 4'h3, 4'h8, 4'h4, 4'h2
    };

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ACCUM,
        ST_DONE
    } state_e;

    // Shift-and-add GF(16) product. With one operand constant this
    // collapses to a fixed XOR network, never an adder.
    function automatic logic [3:0] gf_mul(
        input logic [3:0] a,
        input logic [3:0] b
    );
        logic [3:0] p;
        logic [3:0] x;
        p = '0;
        x = a;
        for (int i = 0; i < 4; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[2:0], 1'b0} ^ (x[3] ? PRIM_POLY : 4'b0000);
        end
        return p;
    endfunction

endpackage

// File: rtl/gf16_mult_const.sv
// Multiplies a GF(16) symbol by a fixed power of alpha (pure XOR logic).
// Ports: a_i symbol in, p_o product out; COEF selects the constant.
module gf16_mult_const
    import rs_pkg::*;
#(
    parameter logic [3:0] COEF = 4'h2
) (
    input  logic [3:0] a_i,
    output logic [3:0] p_o
);

    assign p_o = gf_mul(a_i, COEF);

endmodule

// File: rtl/rs_syndrome_calc.sv
// RS(15,9) syndrome calculator: S_j = r(alpha^j), j=1..6, via Horner's rule.
// Ports: clk, reset (sync, active high), codeWordVector[59:0], startSyndrome
// in; syndromeBusy, syndromeValid, syndromePacked[23:0], errorDetected out.
module rs_syndrome_calc #(
    parameter int SYM_W  = 4,
    parameter int N_SYM  = 15,
    parameter int N_SYND = 6
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [N_SYM*SYM_W-1:0]    codeWordVector,
    input  logic                      startSyndrome,
    output logic                      syndromeBusy,
    output logic                      syndromeValid,
    output logic [N_SYND*SYM_W-1:0]   syndromePacked,
    output logic                      errorDetected
);

    import rs_pkg::*;

    localparam int CW_W = N_SYM * SYM_W;

    state_e                         state_q, state_d;
    logic [3:0]                     cnt_q, cnt_d;
    logic [CW_W-1:0]                cw_q, cw_d;
    logic [N_SYND-1:0][SYM_W-1:0]   acc_q, acc_d;
    logic [N_SYND-1:0][SYM_W-1:0]   mul;
    logic [N_SYND-1:0][SYM_W-1:0]   synd_q, synd_d;
    logic                           err_q, err_d;
    logic                           valid_q, valid_d;
    logic [SYM_W-1:0]               sym;

    // One constant multiplier per syndrome; acc[j] holds S_(j+1).
    for (genvar j = 0; j < N_SYND; j++) begin : g_mul
        gf16_mult_const #(
            .COEF (ALPHA_POW[j+1])
        ) u_mul (
            .a_i (acc_q[j]),
            .p_o (mul[j])
        );
    end

    // Current symbol, highest degree first.
    assign sym = cw_q[cnt_q*SYM_W +: SYM_W];

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        cw_d    = cw_q;
        acc_d   = acc_q;
        synd_d  = synd_q;
        err_d   = err_q;
        valid_d = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (startSyndrome) begin
                    cw_d    = codeWordVector;
                    acc_d   = '0;
                    cnt_d   = 4'(N_SYM - 1);
                    state_d = ST_ACCUM;
                end
            end
            ST_ACCUM: begin
                for (int j = 0; j < N_SYND; j++) begin
                    acc_d[j] = mul[j] ^ sym;
                end
                if (cnt_q == 4'd0) begin
                    state_d = ST_DONE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ST_DONE: begin
                synd_d  = acc_q;
                err_d   = |acc_q;
                valid_d = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            cw_q    <= '0;
            acc_q   <= '0;
            synd_q  <= '0;
            err_q   <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            cw_q    <= cw_d;
            acc_q   <= acc_d;
            synd_q  <= synd_d;
            err_q   <= err_d;
            valid_q <= valid_d;
        end
    end

    assign syndromeBusy   = (state_q != ST_IDLE);
    assign syndromeValid  = valid_q;
    assign syndromePacked = synd_q;
    assign errorDetected  = err_q;

endmodule
